mux_input_conditioner: RTL and testbench

//  Upstream stage of the 2:1 Mux on Basys2 hardware. Conditions raw board

---
 rtl/mux_input_conditioner.sv | 90 +++++++++
 tb/tb_mux_input_conditioner.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mux_input_conditioner.sv
// mux_input_conditioner: synchronises and debounces raw Basys2 switch levels into I0/I1/X,
// with one-cycle rise/fall strobes and a busy flag while any channel is settling.
module mux_input_conditioner #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             busy
);
    typedef enum logic {STABLE, PENDING} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    logic [WIDTH-1:0] s1_q, s2_q, db_q, db_d, rise_q, rise_d, fall_q, fall_d, mis, flip;
    logic             busy_q, busy_d;
    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    assign mis = s2_q ^ db_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            busy_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q   <= raw_in;
            s2_q   <= s1_q;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            busy_q <= busy_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end
    // A mismatch must survive DEBOUNCE_CYCLES consecutive edges at s2; any agreement restarts.
    always_comb begin
        flip   = '0;
        busy_d = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (state_q[i] == STABLE) begin
                cnt_d[i] = '0;
                if (mis[i]) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        flip[i] = 1'b1;
                    end else begin
                        state_d[i] = PENDING;
                        cnt_d[i]   = ONE;
                    end
                end
            end else if (!mis[i]) begin
                state_d[i] = STABLE;
                cnt_d[i]   = '0;
            end else if (cnt_q[i] == LAST) begin
                flip[i]    = 1'b1;
                state_d[i] = STABLE;
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
            end
            busy_d = busy_d | (state_d[i] == PENDING);
        end
        db_d   = db_q ^ flip;
        rise_d = flip & ~db_q;
        fall_d = flip & db_q;
    end
    always_comb begin
        db_out     = db_q;
        rise_pulse = rise_q;
        fall_pulse = fall_q;
        busy       = busy_q;
    end
endmodule

// File: tb/tb_mux_input_conditioner.sv
// tb_mux_input_conditioner: directed checks of debounce latency, glitch rejection, strobes,
// async reset and the downstream 2:1 mux function, with DEBOUNCE_CYCLES=4.
module tb_mux_input_conditioner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] raw_in = 3'b000;
    logic [2:0] db_out, rise_pulse, fall_pulse;
    logic       busy;
    int         total = 0;
    int         bad = 0;

    mux_input_conditioner #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .db_out(db_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] v;
        #1;
        repeat (2) tick();
        rst_n = 1'b1;
        raw_in = 3'b111;
        repeat (8) tick();
        check("pre_reset_db", 16'(db_out), 16'h7);
        // T1: async assertion between edges
        raw_in = 3'b111;
        #3;
        rst_n = 1'b0;
        #1;
        check("t1_async", 16'({db_out, rise_pulse, fall_pulse, busy}), 16'h0);
        repeat (2) tick();
        check("t1_hold", 16'({db_out, rise_pulse, fall_pulse, busy}), 16'h0);
        raw_in = 3'b000;
        rst_n = 1'b1;
        // T2: clean press on I0
        raw_in = 3'b001;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check("t2_db", 16'(db_out), (e >= 6) ? 16'h1 : 16'h0);
            check("t2_rise", 16'(rise_pulse), (e == 6) ? 16'h1 : 16'h0);
            check("t2_fall", 16'(fall_pulse), 16'h0);
            check("t2_busy", 16'(busy), (e >= 3 && e <= 5) ? 16'h1 : 16'h0);
        end
        // T3: 3-cycle glitch on I1
        raw_in = 3'b011;
        for (int e = 1; e <= 9; e++) begin
            if (e == 4) raw_in = 3'b001;
            tick();
            check("t3_db", 16'(db_out), 16'h1);
            check("t3_strobes", 16'({rise_pulse, fall_pulse}), 16'h0);
            check("t3_busy", 16'(busy), (e >= 3 && e <= 5) ? 16'h1 : 16'h0);
        end
        // T4: X bounces 1,0,1,0 then holds 1 from edge 5
        for (int e = 1; e <= 12; e++) begin
            raw_in = (e <= 4 && (e % 2) == 0) ? 3'b001 : 3'b101;
            tick();
            check("t4_db", 16'(db_out), (e >= 10) ? 16'h5 : 16'h1);
            check("t4_rise", 16'(rise_pulse), (e == 10) ? 16'h4 : 16'h0);
        end
        // T5: simultaneous multi-channel changes
        raw_in = 3'b011;
        repeat (5) tick();
        check("t5a_before", 16'(db_out), 16'h5);
        tick();
        check("t5a_db", 16'(db_out), 16'h3);
        check("t5a_rise", 16'(rise_pulse), 16'h2);
        check("t5a_fall", 16'(fall_pulse), 16'h4);
        raw_in = 3'b100;
        repeat (5) tick();
        check("t5b_before", 16'(db_out), 16'h3);
        check("t5b_busy", 16'(busy), 16'h1);
        tick();
        check("t5b_db", 16'(db_out), 16'h4);
        check("t5b_rise", 16'(rise_pulse), 16'h4);
        check("t5b_fall", 16'(fall_pulse), 16'h3);
        tick();
        check("t5b_after", 16'({db_out, rise_pulse, fall_pulse, busy}), 16'({3'b100, 7'b0}));
        // T6: reset while a rise is pending at count 2
        raw_in = 3'b000;
        repeat (8) tick();
        check("t6_clear", 16'(db_out), 16'h0);
        raw_in = 3'b001;
        repeat (4) tick();
        check("t6_pending", 16'(busy), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_in_reset", 16'({db_out, busy}), 16'h0);
        repeat (2) tick();
        check("t6_hold", 16'(db_out), 16'h0);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check("t6_db", 16'(db_out), (e >= 6) ? 16'h1 : 16'h0);
            check("t6_rise", 16'(rise_pulse), (e == 6) ? 16'h1 : 16'h0);
        end
        // Sweep all I0/I1/X combinations through the downstream mux
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            raw_in = v;
            repeat (8) tick();
            check("sweep_db", 16'(db_out), 16'(v));
            check("sweep_f", 16'(db_out[2] ? db_out[1] : db_out[0]), 16'(v[2] ? v[1] : v[0]));
            check("sweep_fbar", 16'(~(db_out[2] ? db_out[1] : db_out[0])), 16'(~(v[2] ? v[1] : v[0])));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
